// File: rtl/ram_hs_burst_reader.sv
// Burst read initiator for a handshake SRAM bank: issues sequential read addresses
// under a credit limit, buffers returned words and streams them out with a last flag.
module ram_hs_burst_reader #(
  parameter int SRAM_WIDTH = 128,
  parameter int ADDR_W     = 6,
  parameter int LEN_W      = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic                  cfg_idle,
  output logic                  done,
  output logic                  err,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_W-1:0]     araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [SRAM_WIDTH-1:0] rdata,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [SRAM_WIDTH-1:0] odata,
  output logic                  olast
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = LEN_W + CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [LEN_W-1:0]      len_q, issued, returned, popped, inflight;
  logic [SRAM_WIDTH-1:0] buf_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [SW-1:0]         occupied;
  logic                  start_acc, start_go, ar_hs, r_hs, push, pop, final_pop;

  assign start_acc = cfg_start && (state == IDLE);
  assign start_go  = start_acc && (cfg_len != '0);
  assign inflight  = issued - returned;
  // Buffered words plus outstanding reads must never exceed the buffer depth.
  assign occupied  = SW'(fifo_count) + SW'(inflight);
  assign ar_hs     = arvalid && arready;
  assign rready    = fifo_count < CW'(FIFO_DEPTH);
  assign r_hs      = rvalid && rready;
  assign push      = r_hs && (inflight != '0);
  assign ovalid    = fifo_count != '0;
  assign odata     = buf_mem[rd_ptr];
  assign pop       = ovalid && oready;
  assign olast     = ovalid && (popped == len_q - LEN_W'(1));
  assign final_pop = pop && (popped == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = RUN;
      RUN:     if (ar_hs && (issued == len_q - LEN_W'(1))) state_nxt = DRAIN;
      DRAIN:   if (final_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_idle = (state == IDLE);
    arvalid  = (state == RUN) && (issued < len_q) && (occupied < SW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      issued   <= '0;
      returned <= '0;
      popped   <= '0;
      araddr   <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (start_acc && (cfg_len == '0)) || final_pop;
      if (start_go) begin
        len_q    <= cfg_len;
        issued   <= '0;
        returned <= '0;
        popped   <= '0;
        araddr   <= cfg_base;
        err      <= 1'b0;
      end else begin
        if (ar_hs) begin
          issued <= issued + LEN_W'(1);
          araddr <= araddr + ADDR_W'(1);
        end
        if (push) returned <= returned + LEN_W'(1);
        if (pop)  popped   <= popped + LEN_W'(1);
        // A returned word with nothing outstanding is dropped and flagged.
        if (r_hs && (inflight == '0)) err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= rdata;
  end

endmodule

// File: tb/tb_ram_hs_burst_reader.sv
// Self-checking bench for ram_hs_burst_reader: table-driven bursts, hand-written
// corner sequences and randomized bursts against a word-level reference model.
module tb_ram_hs_burst_reader;

  localparam int SW = 128;
  localparam int AW = 6;
  localparam int LW = 7;
  localparam int FD = 4;
  localparam int NADDR = 1 << AW;

  typedef struct {
    int base;
    int len;
    int stall;
    int restart;
    int exp_last_addr;
    int exp_done_cyc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_idle, done, err, arvalid, arready, rvalid, rready;
  logic          ovalid, oready, olast;
  logic [AW-1:0] araddr;
  logic [SW-1:0] rdata, odata;

  logic          bank_en = 1'b1;
  logic          spur = 1'b0;
  logic          bank_rvalid;
  logic [SW-1:0] bank_rdata;
  logic [SW-1:0] bank_mem [NADDR];

  int checks = 0;
  int failures = 0;

  ram_hs_burst_reader #(.SRAM_WIDTH(SW), .ADDR_W(AW), .LEN_W(LW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_idle(cfg_idle), .done(done), .err(err), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .rvalid(rvalid), .rready(rready), .rdata(rdata), .ovalid(ovalid),
    .oready(oready), .odata(odata), .olast(olast)
  );

  always #5 clk = ~clk;

  // Bank: one-cycle read latency, address accepted whenever its data side is ready.
  assign arready = rready && bank_en;
  assign rvalid  = bank_rvalid | spur;
  assign rdata   = spur ? {4{32'hDEADBEEF}} : bank_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_rvalid <= 1'b0;
      bank_rdata  <= '0;
    end else begin
      bank_rvalid <= arvalid && arready;
      bank_rdata  <= bank_mem[araddr];
    end
  end

  task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] idleVector();
    return SW'({arvalid, araddr, rready, ovalid, olast, done, err, cfg_idle});
  endfunction

  function automatic logic [SW-1:0] idleExpected();
    logic [AW-1:0] z;
    z = '0;
    return SW'({1'b0, z, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
  endfunction

  // Runs one burst; the model expects address base+k mod 2^AW and word bank_mem[that address].
  task automatic applyStimulus(input vec_t v, input int or_pct, input int ar_pct, input string tag);
    int na, np, nd, done_cyc, last_addr, stall_issues, budget, cyc;
    bit err_seen, stall_arv;
    na = 0; np = 0; nd = 0; done_cyc = -1; last_addr = -1; stall_issues = 0;
    err_seen = 0; stall_arv = 0;
    budget = 20 * v.len + 60;
    @(negedge clk);
    cfg_base  = AW'(v.base);
    cfg_len   = LW'(v.len);
    cfg_start = 1'b1;
    oready    = 1'b0;
    bank_en   = 1'b1;
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      cfg_start = (cyc == v.restart);
      if (cyc == v.restart) begin
        cfg_base = AW'(40);
        cfg_len  = LW'(3);
      end
      oready  = (cyc <= v.stall) ? 1'b0 : ($urandom_range(0, 99) < or_pct);
      bank_en = ($urandom_range(0, 99) < ar_pct);
      #1;
      if (arvalid && arready) begin
        checkOutput({tag, " araddr"}, SW'(araddr), SW'((v.base + na) % NADDR));
        last_addr = int'(araddr);
        na++;
        if (cyc <= v.stall) stall_issues++;
      end
      if (v.stall > 0 && cyc == v.stall) stall_arv = arvalid;
      if (ovalid && oready) begin
        checkOutput({tag, " odata"}, odata, bank_mem[(v.base + np) % NADDR]);
        checkOutput({tag, " olast"}, SW'(olast), SW'(np == v.len - 1));
        np++;
      end
      if (cyc >= 1 && err) err_seen = 1;
      if (done) begin
        nd++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    cfg_start = 1'b0;
    checkOutput({tag, " address count"}, SW'(na), SW'(v.len));
    checkOutput({tag, " word count"}, SW'(np), SW'(v.len));
    checkOutput({tag, " done pulses"}, SW'(nd), SW'(1));
    checkOutput({tag, " err clear"}, SW'(err_seen), SW'(0));
    if (v.exp_done_cyc >= 0)
      checkOutput({tag, " done cycle"}, SW'(done_cyc), SW'(v.exp_done_cyc));
    if (v.len > 0)
      checkOutput({tag, " last address"}, SW'(last_addr), SW'(v.exp_last_addr));
    if (v.stall > 0) begin
      checkOutput({tag, " read-ahead"}, SW'(stall_issues), SW'((v.len < FD) ? v.len : FD));
      checkOutput({tag, " arvalid stalled"}, SW'(stall_arv), SW'(0));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;
    int nd, act;

    tbl[0] = '{5, 4, 0, 0, 8, 7};
    tbl[1] = '{62, 4, 0, 0, 1, 7};
    tbl[2] = '{0, 0, 0, 0, -1, 1};
    tbl[3] = '{0, 1, 0, 0, 0, 4};
    tbl[4] = '{63, 2, 0, 0, 0, 5};
    tbl[5] = '{10, 8, 10, 0, 17, 19};
    tbl[6] = '{5, 6, 0, 2, 10, 9};
    tbl[7] = '{3, 127, 0, 0, 1, 130};

    for (int a = 0; a < NADDR; a++) bank_mem[a] = SW'(a);
    oready = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checkOutput("reset idle", idleVector(), idleExpected());
    end

    // Spurious return with nothing outstanding.
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    checkOutput("spurious err", SW'(err), SW'(1));
    checkOutput("spurious fifo", SW'(ovalid), SW'(0));
    repeat (3) @(negedge clk);
    #1;
    checkOutput("err sticky", SW'(err), SW'(1));

    for (int i = 0; i < 8; i++) applyStimulus(tbl[i], 100, 100, $sformatf("vec%0d", i));

    // Reset in the middle of a burst.
    @(negedge clk);
    cfg_base = AW'(0); cfg_len = LW'(20); cfg_start = 1'b1; oready = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-burst reset", idleVector(), idleExpected());
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0; act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (done) nd++;
      if (arvalid || ovalid) act++;
    end
    checkOutput("no done after reset", SW'(nd), SW'(0));
    checkOutput("quiet after reset", SW'(act), SW'(0));

    for (int a = 0; a < NADDR; a++) bank_mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 15; i++) begin
      rv.base = $urandom_range(0, NADDR - 1);
      rv.len = $urandom_range(1, 40);
      rv.stall = 0;
      rv.restart = 0;
      rv.exp_last_addr = (rv.base + rv.len - 1) % NADDR;
      rv.exp_done_cyc = -1;
      applyStimulus(rv, 60, 75, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_hs_burst_reader.md
# ram_hs_burst_reader

Read-side initiator for the handshake SRAM wrapper's address/data channels (arvalid/arready/araddr, rvalid/rready/rdata). Given a base address and word count, it issues sequential read addresses and collects the returned words in a small internal FIFO. It then presents them as a valid/ready stream with a last flag. It sits between a compute-side consumer (PE array feeder, DMA out) and one handshake SRAM bank, and absorbs the bank's one-cycle read latency without losing throughput.

## Interface
- SRAM_WIDTH, 128, data word width in bits
- ADDR_W, 6, SRAM address width; addresses wrap modulo 2^ADDR_W
- LEN_W, 7, width of burst length; max burst 2^LEN_W-1 words
- FIFO_DEPTH, 4, internal return-buffer depth in words (≥3 required for full throughput)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  one-cycle start pulse; sampled only when cfg_idle=1
- cfg_base  in  ADDR_W  first word address, sampled with cfg_start
- cfg_len  in  LEN_W  number of words, sampled with cfg_start
- cfg_idle  out  1  high in IDLE
- done  out  1  one-cycle pulse when the burst is fully delivered
- err  out  1  sticky: rvalid accepted with no read outstanding; cleared on next accepted start
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready (the bank ties it to rready)
- araddr  out  ADDR_W  read address
- rvalid  in  1  read-data valid from bank
- rready  out  1  read-data ready to bank
- rdata  in  SRAM_WIDTH  read data from bank
- ovalid  out  1  output stream valid
- oready  in  1  output stream ready
- odata  out  SRAM_WIDTH  output word
- olast  out  1  high with the final word of the burst

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: cfg_start with cfg_len>0 latches base/len, clears counters and err, and enters RUN. cfg_start with cfg_len=0 pulses done on the next cycle and stays IDLE. cfg_start outside IDLE is ignored.
- Counters: issued, returned, popped, each LEN_W bits.
- inflight = issued − returned. It is 0 or 1 with this bank.
- credit = FIFO_DEPTH − fifo_count − inflight.
- arvalid = (state==RUN) && issued<len && credit>0. It is combinational from registered state.
- araddr = (base + issued) mod 2^ADDR_W. It is registered and increments on each arvalid&&arready.
- rready = fifo_count < FIFO_DEPTH. The credit rule guarantees space for every outstanding read.
- rvalid&&rready: push rdata to FIFO, returned++. If inflight==0 at that moment, the word is dropped and err is set.
- RUN→DRAIN when issued==len after an address handshake.
- DRAIN→IDLE when popped==len. done pulses in the cycle after the final pop.
- Output: ovalid = fifo not empty; odata = FIFO head; pop on ovalid&&oready, popped++.
- olast = ovalid && (popped == len−1).
- Simultaneous push and pop leaves fifo_count unchanged. Simultaneous issue and return leaves inflight unchanged.
- Words are delivered strictly in address order.

## Timing
- Reset values: arvalid=0, araddr=0, rready=1, ovalid=0, olast=0, done=0, err=0, cfg_idle=1, state=IDLE, FIFO empty, all counters 0.
- Reset asserted mid-burst: all state returns to reset values immediately. No done pulse is produced.
- Start accepted at edge 0. arvalid is high in cycle 1, rvalid in cycle 2, ovalid in cycle 3. First-word latency is 3 cycles.
- Steady state with oready=1 and FIFO_DEPTH≥3: one address issued and one word delivered per cycle. A burst of N words completes its last pop at cycle N+2. done pulses in cycle N+3.
- With oready=0, at most FIFO_DEPTH words are read ahead. arvalid then deasserts. No word is lost or duplicated.
- rready is never deasserted while a read is outstanding and the FIFO is full (credit invariant).

## Test plan
- Reset then idle 10 cycles -> all outputs hold their reset values; no arvalid.
- base=5, len=4, oready=1, bank preloaded mem[a]=a -> araddr 5,6,7,8 in cycles 1-4; odata 5,6,7,8 in cycles 3-6; olast only in cycle 6; done in cycle 7.
- base=62, len=4 (ADDR_W=6) -> araddr 62,63,0,1; odata in that order.
- len=8, oready=0 for 10 cycles, then 1 -> exactly 4 address handshakes, then arvalid=0. After release, all 8 words arrive in order with no gaps beyond the 1-cycle restart; done once.
- len=0 start -> done pulse the next cycle; arvalid never asserted. A second cfg_start mid-burst is ignored (araddr sequence unchanged).
- Force rvalid=1 with no read outstanding -> err=1 and stays high; the FIFO is unchanged; the next accepted start clears err. Reset mid-burst -> reset values; no done.
